// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator request scheduler.
package elevator_pkg;

  localparam int FLOOR_W    = 5;
  localparam int MAX_FLOORS = 15;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DN   = 2'b10
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN,
    DWELL
  } sched_state_t;

endpackage

// File: rtl/elevator_request_scheduler_if.sv
// Call inputs, car position and scheduler outputs towards the elevator Controller.
// call_req is a one-cycle pulse per floor with no back-pressure: every set bit is
// taken on the clock edge where it is seen. All outputs are valid every cycle.
interface elevator_request_scheduler_if #(parameter int NUM_FLOORS = 15);
  import elevator_pkg::*;

  logic [NUM_FLOORS-1:0] call_req;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  at_floor;
  logic [FLOOR_W-1:0]    target_floor;
  dir_t                  direction;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;
  logic                  busy;
  sched_state_t          state;

  modport master (
    output call_req, current_floor, at_floor,
    input  target_floor, direction, door_open, pending, busy, state
  );

  modport slave (
    input  call_req, current_floor, at_floor,
    output target_floor, direction, door_open, pending, busy, state
  );

endinterface

// File: rtl/elevator_request_scheduler_floor_seek.sv
// Combinational search for the nearest pending floor above and below the car.
module floor_seek
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = MAX_FLOORS
) (
  input  logic [NUM_FLOORS-1:0] pending_i,
  input  logic [FLOOR_W-1:0]    current_floor_i,
  output logic                  up_hit_o,
  output logic [FLOOR_W-1:0]    up_floor_o,
  output logic                  dn_hit_o,
  output logic [FLOOR_W-1:0]    dn_floor_o
);

  // Scan order makes the last match win: lowest floor above, highest floor below.
  always_comb begin
    up_hit_o   = 1'b0;
    up_floor_o = '0;
    dn_hit_o   = 1'b0;
    dn_floor_o = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_i[i] && (FLOOR_W'(i) > current_floor_i)) begin
        up_hit_o   = 1'b1;
        up_floor_o = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_i[i] && (FLOOR_W'(i) < current_floor_i)) begin
        dn_hit_o   = 1'b1;
        dn_floor_o = FLOOR_W'(i);
      end
    end
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// LOOK-policy call scheduler: latches floor calls, steers the car and times the door dwell.
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = 15,
  parameter int DWELL_CYCLES = 4
) (
  input logic                         clk,
  input logic                         reset,
  elevator_request_scheduler_if.slave bus
);

  localparam int             CNT_W      = $clog2(DWELL_CYCLES) + 1;
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  sched_state_t          state_q, state_d;
  dir_t                  dir_q, dir_d;
  logic [FLOOR_W-1:0]    target_q, target_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [NUM_FLOORS-1:0] cur_mask, call_in, clear_mask;
  logic                  cur_valid, cur_pend, call_here, dwell_entry;
  logic                  up_hit, dn_hit;
  logic [FLOOR_W-1:0]    up_floor, dn_floor, dist_up, dist_dn;

  floor_seek #(.NUM_FLOORS(NUM_FLOORS)) u_seek (
    .pending_i       (pending_q),
    .current_floor_i (bus.current_floor),
    .up_hit_o        (up_hit),
    .up_floor_o      (up_floor),
    .dn_hit_o        (dn_hit),
    .dn_floor_o      (dn_floor)
  );

  assign cur_valid = bus.current_floor < FLOOR_W'(NUM_FLOORS);
  assign cur_mask  = cur_valid ? (NUM_FLOORS'(1) << bus.current_floor) : '0;
  assign cur_pend  = |(pending_q & cur_mask);
  assign call_here = (state_q == DWELL) && |(bus.call_req & cur_mask);
  assign dist_up   = up_floor - bus.current_floor;
  assign dist_dn   = bus.current_floor - dn_floor;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    // An out-of-range position freezes steering until the car reports a real floor.
    if (cur_valid) begin
      case (state_q)
        IDLE: begin
          target_d = bus.current_floor;
          dir_d    = DIR_NONE;
          if (cur_pend) begin
            state_d = DWELL;
          end else if (up_hit && (!dn_hit || (dist_up <= dist_dn))) begin
            state_d  = UP;
            dir_d    = DIR_UP;
            target_d = up_floor;
          end else if (dn_hit) begin
            state_d  = DOWN;
            dir_d    = DIR_DN;
            target_d = dn_floor;
          end
        end
        UP, DOWN: begin
          if (cur_pend && (bus.current_floor == target_q)) begin
            if (bus.at_floor) begin
              state_d  = DWELL;
              target_d = bus.current_floor;
            end
          end else if ((state_q == UP) && up_hit) begin
            target_d = up_floor;
          end else if ((state_q == DOWN) && dn_hit) begin
            target_d = dn_floor;
          end else begin
            state_d  = IDLE;
            dir_d    = DIR_NONE;
            target_d = bus.current_floor;
          end
        end
        DWELL: begin
          target_d = bus.current_floor;
          if (call_here) begin
            cnt_d = DWELL_LOAD;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if ((dir_q == DIR_UP) && up_hit) begin
            state_d  = UP;
            target_d = up_floor;
          end else if (dn_hit) begin
            state_d  = DOWN;
            dir_d    = DIR_DN;
            target_d = dn_floor;
          end else if (up_hit) begin
            state_d  = UP;
            dir_d    = DIR_UP;
            target_d = up_floor;
          end else begin
            state_d = IDLE;
            dir_d   = DIR_NONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if ((state_d == DWELL) && (state_q != DWELL)) cnt_d = DWELL_LOAD;
  end

  // The clear is applied after the set, so a call racing its own service stays clear.
  assign dwell_entry = (state_d == DWELL) && (state_q != DWELL);
  assign call_in     = bus.call_req & ~((state_q == DWELL) ? cur_mask : '0);
  assign clear_mask  = dwell_entry ? cur_mask : '0;
  assign pending_d   = (pending_q | call_in) & ~clear_mask;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      dir_q     <= DIR_NONE;
      target_q  <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign bus.target_floor = target_q;
  assign bus.direction    = dir_q;
  assign bus.door_open    = (state_q == IDLE) || (state_q == DWELL);
  assign bus.pending      = pending_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.state        = state_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for the scheduler with a simple car model moving one floor per clock.
module tb_elevator_request_scheduler;
  import elevator_pkg::*;

  localparam int NF = 15;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  elevator_request_scheduler_if #(.NUM_FLOORS(NF)) bus ();

  elevator_request_scheduler #(.NUM_FLOORS(NF), .DWELL_CYCLES(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; then the car steps one floor toward target while the door is shut.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!bus.door_open && (bus.current_floor != bus.target_floor)) begin
      if (bus.current_floor < bus.target_floor) bus.current_floor = bus.current_floor + 5'd1;
      else                                      bus.current_floor = bus.current_floor - 5'd1;
    end
    bus.at_floor = (bus.current_floor == bus.target_floor);
  endtask

  task automatic wait_state(input sched_state_t s, input int budget, input string tag,
                            output int n);
    n = 0;
    while ((bus.state != s) && (n < budget)) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.state), 32'(s));
  endtask

  task automatic wait_floor(input logic [4:0] f, input int budget, input string tag);
    int n = 0;
    while ((bus.current_floor != f) && (n < budget)) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.current_floor), 32'(f));
  endtask

  task automatic do_reset(input logic [4:0] f);
    reset             = 1'b0;
    bus.call_req      = '0;
    bus.current_floor = f;
    bus.at_floor      = 1'b1;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic pulse(input logic [NF-1:0] calls);
    bus.call_req = calls;
    tick();
    bus.call_req = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dw;

    // Reset held with every call asserted: nothing may be latched.
    reset             = 1'b0;
    bus.call_req      = '1;
    bus.current_floor = 5'd0;
    bus.at_floor      = 1'b1;
    repeat (2) tick();
    chk("rst_pending", 32'(bus.pending), 32'h0);
    chk("rst_target", 32'(bus.target_floor), 32'd0);
    chk("rst_dir", 32'(bus.direction), 32'(DIR_NONE));
    chk("rst_door", 32'(bus.door_open), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset        = 1'b1;
    bus.call_req = '0;
    tick();

    // Single call to floor 5 from rest at 0.
    pulse(15'h0020);
    chk("t2_pend", 32'(bus.pending), 32'h0020);
    tick();
    chk("t2_target", 32'(bus.target_floor), 32'd5);
    chk("t2_dir", 32'(bus.direction), 32'(DIR_UP));
    chk("t2_door", 32'(bus.door_open), 32'd0);
    wait_state(DWELL, 20, "t2_arrive", n);
    chk("t2_travel", 32'(n), 32'd5);
    chk("t2_floor", 32'(bus.current_floor), 32'd5);
    chk("t2_clear", 32'(bus.pending), 32'h0);
    dw = 0;
    while ((bus.state == DWELL) && (dw < 20)) begin
      chk("t2_door_dwell", 32'(bus.door_open), 32'd1);
      dw++;
      tick();
    end
    chk("t2_dwell_len", 32'(dw), 32'd4);
    chk("t2_idle", 32'(bus.state), 32'(IDLE));

    // Heading for 9, a call at 4 arrives while the car is at 2.
    do_reset(5'd0);
    pulse(15'h0200);
    tick();
    wait_floor(5'd2, 20, "t3_at2");
    pulse(15'h0010);
    chk("t3_pend", 32'(bus.pending), 32'h0210);
    tick();
    chk("t3_retarget", 32'(bus.target_floor), 32'd4);
    wait_state(DWELL, 20, "t3_stop4", n);
    chk("t3_floor4", 32'(bus.current_floor), 32'd4);
    chk("t3_pend4", 32'(bus.pending), 32'h0200);
    wait_state(UP, 10, "t3_resume", n);
    chk("t3_target9", 32'(bus.target_floor), 32'd9);
    wait_state(DWELL, 20, "t3_stop9", n);
    chk("t3_floor9", 32'(bus.current_floor), 32'd9);
    wait_state(IDLE, 10, "t3_idle", n);
    chk("t3_dir_idle", 32'(bus.direction), 32'(DIR_NONE));

    // Going up past 6 with calls at 3 and 10: finish upward first, then reverse.
    do_reset(5'd0);
    pulse(15'h0400);
    wait_floor(5'd6, 20, "t4_at6");
    pulse(15'h0008);
    chk("t4_pend", 32'(bus.pending), 32'h0408);
    chk("t4_dir_up", 32'(bus.direction), 32'(DIR_UP));
    chk("t4_target10", 32'(bus.target_floor), 32'd10);
    wait_state(DWELL, 20, "t4_stop10", n);
    chk("t4_floor10", 32'(bus.current_floor), 32'd10);
    chk("t4_dir_dwell", 32'(bus.direction), 32'(DIR_UP));
    wait_state(DOWN, 10, "t4_reverse", n);
    chk("t4_dir_dn", 32'(bus.direction), 32'(DIR_DN));
    chk("t4_target3", 32'(bus.target_floor), 32'd3);
    wait_state(DWELL, 20, "t4_stop3", n);
    chk("t4_floor3", 32'(bus.current_floor), 32'd3);
    wait_state(IDLE, 10, "t4_idle", n);
    chk("t4_dir_idle", 32'(bus.direction), 32'(DIR_NONE));

    // Idle at 7 with 5 and 9 called together: tie resolves upward.
    do_reset(5'd7);
    pulse(15'h0220);
    chk("t5_pend", 32'(bus.pending), 32'h0220);
    tick();
    chk("t5_state", 32'(bus.state), 32'(UP));
    chk("t5_target", 32'(bus.target_floor), 32'd9);
    chk("t5_dir", 32'(bus.direction), 32'(DIR_UP));
    wait_state(DWELL, 20, "t5_stop9", n);
    chk("t5_floor9", 32'(bus.current_floor), 32'd9);
    wait_state(DOWN, 10, "t5_reverse", n);
    chk("t5_target5", 32'(bus.target_floor), 32'd5);

    // Dwell at 4 extended by a repeat call on the stop's floor; 14 latched meanwhile.
    do_reset(5'd0);
    pulse(15'h0010);
    wait_state(DWELL, 20, "t6_stop4", n);
    chk("t6_floor4", 32'(bus.current_floor), 32'd4);
    tick();
    chk("t6_still_dwell", 32'(bus.state), 32'(DWELL));
    dw = 2;
    pulse(15'h4010);
    chk("t6_pend", 32'(bus.pending), 32'h4000);
    while ((bus.state == DWELL) && (dw < 30)) begin
      dw++;
      tick();
    end
    chk("t6_dwell_len", 32'(dw), 32'd6);
    chk("t6_state_up", 32'(bus.state), 32'(UP));
    chk("t6_target14", 32'(bus.target_floor), 32'd14);
    chk("t6_dir", 32'(bus.direction), 32'(DIR_UP));

    // Car reports an impossible floor: steering holds.
    bus.current_floor = 5'd20;
    tick();
    chk("oor_state", 32'(bus.state), 32'(UP));
    chk("oor_target", 32'(bus.target_floor), 32'd14);
    chk("oor_pend", 32'(bus.pending), 32'h4000);

    // Reset while travelling up discards everything in one cycle.
    bus.current_floor = 5'd6;
    reset             = 1'b0;
    tick();
    chk("mid_rst_state", 32'(bus.state), 32'(IDLE));
    chk("mid_rst_pend", 32'(bus.pending), 32'h0);
    chk("mid_rst_target", 32'(bus.target_floor), 32'd0);
    chk("mid_rst_dir", 32'(bus.direction), 32'(DIR_NONE));
    chk("mid_rst_door", 32'(bus.door_open), 32'd1);
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_request_scheduler.md
Name: elevator_request_scheduler

Overview:
Collects floor calls from car and hall buttons into a pending mask. Applies a LOOK policy: keep travelling in the current direction while calls remain ahead, then reverse. Drives the elevator Controller's requested_floor each cycle. Times the door dwell at each serviced floor and holds the car there until the dwell expires.

Parameters:
NUM_FLOORS, 15, number of serviceable floors (0..NUM_FLOORS-1); max 15, because the Controller ignores requests >= 15
FLOOR_W, 5, floor index width; matches Controller requested_floor/y
DWELL_CYCLES, 4, clock cycles the door is held open at a serviced floor (>= 1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
call_req  input  NUM_FLOORS  one-cycle call pulses, one bit per floor; multiple bits may be set in the same cycle
current_floor  input  FLOOR_W  car position, from Controller y
at_floor  input  1  car stationary at current_floor, from Controller wait_floor[0]
target_floor  output  FLOOR_W  registered; connects to Controller requested_floor
direction  output  2  01 up, 10 down, 00 none
door_open  output  1  door open command
pending  output  NUM_FLOORS  outstanding call mask
busy  output  1  state != IDLE

Behaviour:
- Reset (reset==0 at posedge clk): state IDLE, pending 0, target_floor 0, direction 00, door_open 1, dwell counter 0. Reset mid-operation discards all calls in one cycle.
- Pending mask:
  - pending[i] is set one cycle after call_req[i].
  - pending[i] is cleared on entry to DWELL when i == current_floor.
  - A call for the current floor while in DWELL is not latched; it reloads the dwell counter.
  - A call arriving in the same cycle as the clear for that floor is treated as serviced (stays clear).
- Seek results are combinational from pending and current_floor:
  - up_hit/up_floor: lowest pending floor > current_floor.
  - dn_hit/dn_floor: highest pending floor < current_floor.
- States:
  - IDLE: target_floor = current_floor, direction 00, door_open 1.
    - pending[current_floor] -> DWELL.
    - Else if up_hit or dn_hit: move toward the nearer; equal distance goes UP.
  - UP: direction 01, door_open 0, target_floor <= up_floor every cycle, so intermediate calls are picked up.
    - current_floor == target_floor && at_floor && pending[current_floor] -> DWELL.
  - DOWN: mirror of UP using dn_floor; direction 10.
  - DWELL: door_open 1, target_floor = current_floor, direction unchanged; counter loads DWELL_CYCLES-1 on entry.
    - On counter == 0: previous direction up and up_hit -> UP; else dn_hit -> DOWN; else up_hit -> UP; else IDLE (direction 00).
- Latency:
  - call_req at edge n -> pending at n+1 -> state/target_floor at n+2.
  - DWELL lasts exactly DWELL_CYCLES cycles, absent reloads.
- Boundaries:
  - call_req bits >= NUM_FLOORS are masked.
  - current_floor >= NUM_FLOORS: no arrival match, seek results invalid; state and target_floor hold.
  - UP with no up_hit (call withdrawn by reset only) cannot occur; if it does, go to IDLE.
- No arithmetic wrap: floor comparisons are unsigned FLOOR_W-bit; the dwell counter is sized clog2(DWELL_CYCLES)+1 bits and saturates at 0.

Decomposition:
- elevator_pkg holds:
  - FLOOR_W and MAX_FLOORS=15.
  - dir_t encodings: DIR_NONE=2'b00, DIR_UP=2'b01, DIR_DN=2'b10.
  - sched_state_t: IDLE, UP, DOWN, DWELL.
- One sub-module, floor_seek: pure combinational priority search. Inputs pending and current_floor; outputs up_hit, up_floor, dn_hit, dn_floor. Verified standalone.

Test Plan (NUM_FLOORS=15, DWELL_CYCLES=4, bench model of Controller moving 1 floor/clk):
- Reset held low 2 cycles with call_req=15'h7FFF -> pending 0, target_floor 0, direction 00, door_open 1, busy 0.
- Idle at 0, call_req[5] pulse -> pending[5] at n+1; target_floor 5, direction 01, door_open 0 at n+2. On arrival: DWELL, pending[5] cleared, door_open 1 for exactly 4 cycles, then IDLE.
- Moving up toward 9, call_req[4] while car at 2 -> target_floor switches to 4. Car stops at 4, dwells, then resumes to 9.
- Car at 6 moving up with pending {3,10} -> services 10 first, then reverses to 3. direction sequence 01, 01 (dwell at 10), 10.
- Idle at 7, pending {5,9} in the same cycle -> equal distance, goes UP to 9 first.
- During DWELL at 4: call_req[4] on the 3rd cycle reloads the counter (dwell extends to 6 cycles total). call_req[15-bit index 14] latched, call_req of out-of-range bit ignored. reset=0 mid-UP -> IDLE next cycle, pending 0.
